// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and default sizing for the UART TX arbiter.
package tx_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      LOAD,
      SEND,
      WAIT_ACK,
      DONE
   } state_t;

   localparam int TX_ARB_N_REQ     = 4;
   localparam int TX_ARB_DATA_W    = 8;
   localparam int TX_ARB_MAX_BURST = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between per-source TX FIFOs/command bits, the arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if
   import tx_arb_pkg::*;
#(
   parameter int N_REQ  = TX_ARB_N_REQ,
   parameter int DATA_W = TX_ARB_DATA_W
) ();

   logic [N_REQ-1:0]        enviar_cmd;
   logic [N_REQ-1:0]        enviar_bit_clear;
   logic [N_REQ-1:0]        fifo_tx_empty;
   logic [N_REQ-1:0]        fifo_tx_rd;
   logic [N_REQ*DATA_W-1:0] fifo_tx_data;
   logic                    uart_tx_rdy;
   logic                    uart_tx_start;
   logic [DATA_W-1:0]       uart_tx_data;
   logic [N_REQ-1:0]        grant;
   logic                    busy;

   modport slave (
      input  enviar_cmd, fifo_tx_empty, fifo_tx_data, uart_tx_rdy,
      output enviar_bit_clear, fifo_tx_rd, uart_tx_start, uart_tx_data, grant, busy
   );

   modport master (
      output enviar_cmd, fifo_tx_empty, fifo_tx_data, uart_tx_rdy,
      input  enviar_bit_clear, fifo_tx_rd, uart_tx_start, uart_tx_data, grant, busy
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first pending source after i_last_ptr, wrapping; purely combinational.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] i_pend,
   input  logic [PTR_W-1:0] i_last_ptr,
   output logic [N_REQ-1:0] o_pick,
   output logic             o_any
);

   always_comb begin
      logic [PTR_W-1:0] w_idx;
      // NOTE: every output gets a default first, so no path through the block infers a latch.
      o_pick = '0;
      o_any  = 1'b0;
      w_idx  = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         w_idx = PTR_W'((int'(i_last_ptr) + off) % N_REQ);
         if (!o_any && i_pend[w_idx]) begin
            o_pick[w_idx] = 1'b1;
            o_any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ FIFO sources, granting round-robin and draining per grant.
// Optional per-grant byte limit: define TX_ARB_BURST_LIMIT_EN.
module uart_tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_REQ  = TX_ARB_N_REQ,
   parameter int DATA_W = TX_ARB_DATA_W
`ifdef TX_ARB_BURST_LIMIT_EN
   ,
   parameter int MAX_BURST = TX_ARB_MAX_BURST
`endif
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(N_REQ);

   state_t            r_state;
   logic [N_REQ-1:0]  r_pend;
   logic [N_REQ-1:0]  r_grant;
   logic [N_REQ-1:0]  r_rd;
   logic [N_REQ-1:0]  r_clear;
   logic [PTR_W-1:0]  r_last_ptr;
   logic              r_busy;
   logic              r_start;
   logic [DATA_W-1:0] r_data;

   logic [N_REQ-1:0]  w_pick;
   logic              w_any;
   logic [N_REQ-1:0]  w_pend_clr;
   logic [PTR_W-1:0]  w_g_idx;
   logic [DATA_W-1:0] w_slice;
   logic              w_empty;
   logic              w_end_grant;

`ifdef TX_ARB_BURST_LIMIT_EN
   localparam int BC_W = $clog2(MAX_BURST + 1);
   logic [BC_W-1:0] r_burst_cnt;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_pend     (r_pend),
      .i_last_ptr (r_last_ptr),
      .o_pick     (w_pick),
      .o_any      (w_any)
   );

   // Decode the one-hot owner into its index, FIFO byte and empty flag.
   always_comb begin
      w_g_idx = '0;
      w_slice = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            w_g_idx = PTR_W'(i);
            w_slice = bus.fifo_tx_data[i*DATA_W +: DATA_W];
         end
      end
      w_empty = |(bus.fifo_tx_empty & r_grant);
`ifdef TX_ARB_BURST_LIMIT_EN
      w_end_grant = w_empty || (r_burst_cnt == BC_W'(MAX_BURST));
      w_pend_clr  = (r_state == DONE && w_empty) ? r_grant : '0;
`else
      w_end_grant = w_empty;
      w_pend_clr  = (r_state == DONE) ? r_grant : '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pend     <= '0;
         r_grant    <= '0;
         r_rd       <= '0;
         r_clear    <= '0;
         r_last_ptr <= PTR_W'(N_REQ - 1);
         r_busy     <= 1'b0;
         r_start    <= 1'b0;
         r_data     <= '0;
`ifdef TX_ARB_BURST_LIMIT_EN
         r_burst_cnt <= '0;
`endif
      end else begin
         // NOTE: non-blocking only, so every register updates from pre-edge values.
         r_pend <= (r_pend & ~w_pend_clr) | bus.enviar_cmd;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= CHECK;
`ifdef TX_ARB_BURST_LIMIT_EN
                  r_burst_cnt <= '0;
`endif
               end
            end
            CHECK: begin
               if (w_end_grant) begin
                  r_clear <= w_empty ? r_grant : '0;
                  r_state <= DONE;
               end else if (bus.uart_tx_rdy) begin
                  r_rd    <= r_grant;
                  r_state <= READ;
               end
            end
            READ: begin
               r_rd    <= '0;
               r_state <= LOAD;
            end
            LOAD: begin
               r_data  <= w_slice;
               r_start <= 1'b1;
               r_state <= SEND;
`ifdef TX_ARB_BURST_LIMIT_EN
               r_burst_cnt <= r_burst_cnt + 1'b1;
`endif
            end
            SEND: begin
               r_start <= 1'b0;
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: r_state <= CHECK;
            DONE: begin
               r_clear    <= '0;
               r_last_ptr <= w_g_idx;
               r_grant    <= '0;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.grant            = r_grant;
   assign bus.busy             = r_busy;
   assign bus.fifo_tx_rd       = r_rd;
   assign bus.enviar_bit_clear = r_clear;
   assign bus.uart_tx_start    = r_start;
   assign bus.uart_tx_data     = r_data;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between N_REQ independent TX sources. Each source has its own TX FIFO and "enviar" command bit. The arbiter latches send requests and grants sources round-robin, one at a time. For the granted source it drains the FIFO byte-by-byte into the UART using the rdy/start handshake, then pulses that source's enviar_bit_clear. It sits between the per-source TX FIFOs/command registers and the single uart_tx instance.

Parameters:
N_REQ, 4, number of requesting sources (2..8)
DATA_W, 8, byte width on FIFO read data and UART data
MAX_BURST, 16, max bytes per grant; used only when the optional feature is compiled in

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
enviar_cmd  in  N_REQ  per-source 1-cycle send request pulse
enviar_bit_clear  out  N_REQ  1-cycle pulse on the source whose transfer completed
fifo_tx_empty  in  N_REQ  per-source FIFO empty flag
fifo_tx_rd  out  N_REQ  one-hot FIFO read strobe, 1 cycle
fifo_tx_data  in  N_REQ*DATA_W  packed FIFO read data; slice i = source i; valid 1 cycle after rd
uart_tx_rdy  in  1  UART idle/ready; drops the cycle after start
uart_tx_start  out  1  1-cycle start pulse to UART
uart_tx_data  out  DATA_W  byte to UART; held stable from start until next load
grant  out  N_REQ  one-hot current owner; 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. pend=0. last_ptr=N_REQ-1, so source 0 wins first. All outputs 0, including uart_tx_data. Reset mid-transfer aborts immediately; no clear pulse is issued.
- pend[i] sets on enviar_cmd[i]=1. It clears in DONE for the granted source. If set and clear coincide on the same bit, set wins and the request stays pending.
- Round-robin selection: search for the first pend bit starting at last_ptr+1, wrapping mod N_REQ.
- States, registered Moore outputs:
  - IDLE: if pend!=0, register the selection into grant, reset burst_cnt to 0, go to CHECK. Otherwise stay.
  - CHECK:
    - if fifo_tx_empty[g], go to DONE;
    - else if uart_tx_rdy, go to READ;
    - else stay.
  - READ: fifo_tx_rd[g]=1 for exactly one cycle; go to LOAD.
  - LOAD: register fifo_tx_data slice g into uart_tx_data; burst_cnt++; go to SEND.
  - SEND: uart_tx_start=1 for one cycle; go to WAIT_ACK.
  - WAIT_ACK: one cycle, ignores rdy; go to CHECK. CHECK then blocks until rdy returns.
  - DONE: enviar_bit_clear[g]=1 for one cycle; clear pend[g]; last_ptr=g; grant=0; go to IDLE.
- Latency: from an enviar_cmd pulse in IDLE (FIFO non-empty, rdy=1) to uart_tx_start is 5 cycles (IDLE, CHECK, READ, LOAD, SEND).
- Back-to-back bytes are spaced by the UART frame time plus 4 cycles.
- A source granted with an empty FIFO completes with 0 bytes: CHECK goes straight to DONE and the clear pulse still occurs.
- Requests arriving during a grant are latched and served afterwards in round-robin order. A new enviar_cmd for the current owner re-sets pend and does not extend the current grant.
- At most one fifo_tx_rd bit is high in any cycle. uart_tx_start is never asserted while uart_tx_rdy was 0 in the preceding CHECK.

Optional Feature:
- Macro TX_ARB_BURST_LIMIT_EN.
- Defined: CHECK also goes to DONE when burst_cnt==MAX_BURST. pend[g] clears only if fifo_tx_empty[g]=1 at DONE. Otherwise pend stays set and the source re-competes after the others, bounding starvation. enviar_bit_clear pulses only when the FIFO was drained.
- Undefined: the owner drains until its FIFO is empty; burst_cnt is absent.

Decomposition:
- Package tx_arb_pkg: state enum (IDLE, CHECK, READ, LOAD, SEND, WAIT_ACK, DONE) and default DATA_W/N_REQ constants.
- Sub-module rr_pick: pend + last_ptr → one-hot next grant plus any-valid flag. Purely combinational, instantiated once.

Test Plan:
- Reset mid-SEND (rst low 1 cycle) → all outputs 0 the same cycle; after release, pend=0 and state=IDLE; the next enviar_cmd[2] gets grant=4'b0100.
- enviar_cmd[0] with FIFO0 holding 0xA5, 0x3C, rdy=1 → two start pulses carrying 0xA5 then 0x3C. The first start is 5 cycles after the cmd. Then one enviar_bit_clear[0] pulse and grant=0.
- enviar_cmd[1] and [3] in the same cycle, last_ptr=1 → source 3 served first, then source 1.
- enviar_cmd[2] with FIFO2 empty → no fifo_tx_rd, no start; enviar_bit_clear[2] pulses 3 cycles after the cmd.
- uart_tx_rdy held 0 for 50 cycles while in CHECK → no rd/start. Start is issued 3 cycles after rdy rises.
- TX_ARB_BURST_LIMIT_EN, MAX_BURST=2: FIFO0 holds 3 bytes and source 1 is pending → bytes 0,1 from source 0, then source 1 drained, then byte 2 of source 0. clear[0] pulses only after the final byte.
